// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read port between the interconnect (master) and the sysid checker (slave).
// The checker forwards accepted reads to the sysid slave and returns registered data.
interface soc_system_sysid_checker_if;
   logic        m_read;
   logic        m_address;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        m_readdatavalid;

   modport master (
      output m_read,
      output m_address,
      input  m_waitrequest,
      input  m_readdata,
      input  m_readdatavalid
   );

   modport slave (
      input  m_read,
      input  m_address,
      output m_waitrequest,
      output m_readdata,
      output m_readdatavalid
   );
endinterface

// File: rtl/soc_system_sysid_checker.sv
// Sequences the sysid slave: a two-cycle self-check of ID and timestamp words after
// reset or on request, then forwards external reads with one cycle of latency.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID = 32'hACD51302,
   parameter logic [31:0] EXPECTED_TS = 32'h56B7D21A,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   soc_system_sysid_checker_if.slave avm,
   output logic                     sys_address,
   input  logic [31:0]              sys_readdata,
   input  logic                     recheck,
   output logic                     check_done,
   output logic                     id_ok,
   output logic                     id_mismatch,
   output logic [CNT_W-1:0]         mismatch_count
);

   localparam logic [1:0] CHK_ID = 2'd0;
   localparam logic [1:0] CHK_TS = 2'd1;
   localparam logic [1:0] SERVE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0] state;
   logic       id_match;
   logic       accept;
   logic       check_ok;

   // NOTE: reset is ORed in so the master is stalled even before the first edge after assertion.
   assign avm.m_waitrequest = (state != SERVE) | reset;
   assign accept            = avm.m_read & ~avm.m_waitrequest;
   assign check_ok          = id_match & (sys_readdata == EXPECTED_TS);

   // NOTE: every branch assigns sys_address, so no latch is inferred.
   always_comb begin
      case (state)
         CHK_ID:  sys_address = 1'b0;
         CHK_TS:  sys_address = 1'b1;
         default: sys_address = avm.m_address;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                <= CHK_ID;
         id_match             <= 1'b0;
         check_done           <= 1'b0;
         id_ok                <= 1'b0;
         id_mismatch          <= 1'b0;
         mismatch_count       <= '0;
         avm.m_readdata       <= '0;
         avm.m_readdatavalid  <= 1'b0;
      end else begin
         avm.m_readdatavalid <= accept;
         if (accept) begin
            avm.m_readdata <= sys_readdata;
         end

         case (state)
            CHK_ID: begin
               id_match <= (sys_readdata == EXPECTED_ID);
               state    <= CHK_TS;
            end
            CHK_TS: begin
               check_done  <= 1'b1;
               id_ok       <= check_ok;
               id_mismatch <= ~check_ok;
               if (!check_ok && mismatch_count != CNT_MAX) begin
                  mismatch_count <= mismatch_count + CNT_W'(1);
               end
               state <= SERVE;
            end
            default: begin
               // A recheck seen here restarts the sequence; one seen mid-check is dropped.
               if (recheck) begin
                  state <= CHK_ID;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Drives two checkers (8-bit and 2-bit mismatch counters) with the same stimulus and
// compares both against a cycle-countdown model every cycle, plus literal spot checks.
module tb_soc_system_sysid_checker;

   localparam logic [31:0] ID = 32'hACD51302;
   localparam logic [31:0] TS = 32'h56B7D21A;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic m_read = 1'b0;
   logic m_address = 1'b0;
   logic recheck = 1'b0;
   logic bad_id = 1'b0;
   logic cmp_en = 1'b0;

   int tests = 0;
   int failed = 0;

   always #5 clock = ~clock;

   soc_system_sysid_checker_if avm_a ();
   soc_system_sysid_checker_if avm_b ();
   assign avm_a.m_read    = m_read;
   assign avm_a.m_address = m_address;
   assign avm_b.m_read    = m_read;
   assign avm_b.m_address = m_address;

   logic        sys_addr_a, sys_addr_b;
   logic [31:0] sys_rd_a, sys_rd_b;
   logic        done_a, ok_a, mis_a;
   logic        done_b, ok_b, mis_b;
   logic [7:0]  cnt_a;
   logic [1:0]  cnt_b;

   // Sysid slave: combinational word per address; bad_id corrupts the ID word.
   function automatic logic [31:0] slave_data(input logic addr);
      if (addr) return TS;
      return bad_id ? 32'h0 : ID;
   endfunction

   assign sys_rd_a = slave_data(sys_addr_a);
   assign sys_rd_b = slave_data(sys_addr_b);

   soc_system_sysid_checker #(.CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .avm(avm_a.slave),
      .sys_address(sys_addr_a), .sys_readdata(sys_rd_a), .recheck(recheck),
      .check_done(done_a), .id_ok(ok_a), .id_mismatch(mis_a), .mismatch_count(cnt_a)
   );

   soc_system_sysid_checker #(.CNT_W(2)) dut_b (
      .clock(clock), .reset(reset), .avm(avm_b.slave),
      .sys_address(sys_addr_b), .sys_readdata(sys_rd_b), .recheck(recheck),
      .check_done(done_b), .id_ok(ok_b), .id_mismatch(mis_b), .mismatch_count(cnt_b)
   );

   // Model: busy counts remaining check cycles (2 = reading ID, 1 = reading TS, 0 = serving).
   int          e_busy = 2;
   logic        e_done = 1'b0, e_ok = 1'b0, e_mis = 1'b0, e_rdv = 1'b0;
   logic [31:0] e_rd = '0;
   int          e_cnt8 = 0, e_cnt2 = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         e_busy <= 2; e_done <= 1'b0; e_ok <= 1'b0; e_mis <= 1'b0;
         e_rdv <= 1'b0; e_rd <= '0; e_cnt8 <= 0; e_cnt2 <= 0;
      end else begin
         e_rdv <= m_read && (e_busy == 0);
         if (m_read && e_busy == 0) e_rd <= slave_data(m_address);
         if (e_busy == 1) begin
            e_done <= 1'b1;
            e_ok   <= (slave_data(1'b0) == ID) && (slave_data(1'b1) == TS);
            e_mis  <= !((slave_data(1'b0) == ID) && (slave_data(1'b1) == TS));
            if (!((slave_data(1'b0) == ID) && (slave_data(1'b1) == TS))) begin
               e_cnt8 <= (e_cnt8 < 255) ? e_cnt8 + 1 : 255;
               e_cnt2 <= (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
            end
         end
         if (e_busy > 0) e_busy <= e_busy - 1;
         else if (recheck) e_busy <= 2;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         logic e_wr;
         logic e_sa;
         e_wr = reset || (e_busy > 0);
         e_sa = (e_busy == 2) ? 1'b0 : (e_busy == 1) ? 1'b1 : m_address;
         check("a.waitrequest", 32'(avm_a.m_waitrequest), 32'(e_wr));
         check("a.readdatavalid", 32'(avm_a.m_readdatavalid), 32'(e_rdv));
         check("a.readdata", avm_a.m_readdata, e_rd);
         check("a.sys_address", 32'(sys_addr_a), 32'(e_sa));
         check("a.check_done", 32'(done_a), 32'(e_done));
         check("a.id_ok", 32'(ok_a), 32'(e_ok));
         check("a.id_mismatch", 32'(mis_a), 32'(e_mis));
         check("a.mismatch_count", 32'(cnt_a), 32'(e_cnt8));
         check("b.waitrequest", 32'(avm_b.m_waitrequest), 32'(e_wr));
         check("b.readdatavalid", 32'(avm_b.m_readdatavalid), 32'(e_rdv));
         check("b.readdata", avm_b.m_readdata, e_rd);
         check("b.id_ok", 32'(ok_b), 32'(e_ok));
         check("b.mismatch_count", 32'(cnt_b), 32'(e_cnt2));
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic do_recheck();
      recheck = 1'b1;
      tick();
      recheck = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #1 reset = 1'b1;
      cmp_en = 1'b1;
      tick();
      tick();
      @(negedge clock);
      check("lit reset done", 32'(done_a), 32'd0);
      check("lit reset waitrequest", 32'(avm_a.m_waitrequest), 32'd1);
      check("lit reset count", 32'(cnt_a), 32'd0);

      // Test 1: clean check after release; two stall cycles.
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("lit t1 wr cyc0", 32'(avm_a.m_waitrequest), 32'd1);
      @(negedge clock);
      check("lit t1 wr cyc1", 32'(avm_a.m_waitrequest), 32'd1);
      @(negedge clock);
      check("lit t1 wr cyc2", 32'(avm_a.m_waitrequest), 32'd0);
      check("lit t1 done", 32'(done_a), 32'd1);
      check("lit t1 ok", 32'(ok_a), 32'd1);
      check("lit t1 mismatch", 32'(mis_a), 32'd0);
      check("lit t1 count", 32'(cnt_a), 32'd0);

      // Tests 2 and 5: bad ID word, counters 1..4 and saturating 1,2,3,3.
      tick();
      bad_id = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         do_recheck();
         @(negedge clock);
         check("lit t2 ok", 32'(ok_a), 32'd0);
         check("lit t2 mismatch", 32'(mis_a), 32'd1);
         check("lit t2 count8", 32'(cnt_a), 32'(i));
         check("lit t5 count2", 32'(cnt_b), (i < 3) ? 32'(i) : 32'd3);
         tick();
      end
      bad_id = 1'b0;
      do_recheck();
      @(negedge clock);
      check("lit t2 recovered ok", 32'(ok_a), 32'd1);
      check("lit t2 count held", 32'(cnt_a), 32'd4);

      // Test 3: back-to-back reads 0,1,0.
      m_read = 1'b1;
      m_address = 1'b0;
      tick();
      m_address = 1'b1;
      @(negedge clock);
      check("lit t3 rdv0", 32'(avm_a.m_readdatavalid), 32'd1);
      check("lit t3 data0", avm_a.m_readdata, ID);
      tick();
      m_address = 1'b0;
      @(negedge clock);
      check("lit t3 rdv1", 32'(avm_a.m_readdatavalid), 32'd1);
      check("lit t3 data1", avm_a.m_readdata, TS);
      tick();
      m_read = 1'b0;
      @(negedge clock);
      check("lit t3 rdv2", 32'(avm_a.m_readdatavalid), 32'd1);
      check("lit t3 data2", avm_a.m_readdata, ID);
      @(negedge clock);
      check("lit t3 rdv idle", 32'(avm_a.m_readdatavalid), 32'd0);

      // Test 4: recheck and read in the same cycle; results refresh to a mismatch.
      bad_id = 1'b1;
      recheck = 1'b1;
      m_read = 1'b1;
      m_address = 1'b1;
      tick();
      recheck = 1'b0;
      m_read = 1'b0;
      @(negedge clock);
      check("lit t4 rdv", 32'(avm_a.m_readdatavalid), 32'd1);
      check("lit t4 data", avm_a.m_readdata, TS);
      check("lit t4 wr cyc0", 32'(avm_a.m_waitrequest), 32'd1);
      tick();
      @(negedge clock);
      check("lit t4 wr cyc1", 32'(avm_a.m_waitrequest), 32'd1);
      check("lit t4 old ok held", 32'(ok_a), 32'd1);
      tick();
      @(negedge clock);
      check("lit t4 wr serve", 32'(avm_a.m_waitrequest), 32'd0);
      check("lit t4 new ok", 32'(ok_a), 32'd0);
      check("lit t4 count", 32'(cnt_a), 32'd5);

      // Test 6: recheck during CHK_ID ignored; held read accepted once in SERVE.
      recheck = 1'b1;
      tick();
      m_read = 1'b1;
      m_address = 1'b1;
      @(negedge clock);
      check("lit t6 wr chk_id", 32'(avm_a.m_waitrequest), 32'd1);
      tick();
      recheck = 1'b0;
      @(negedge clock);
      check("lit t6 stalled", 32'(avm_a.m_readdatavalid), 32'd0);
      tick();
      @(negedge clock);
      check("lit t6 serve", 32'(avm_a.m_waitrequest), 32'd0);
      check("lit t6 count once", 32'(cnt_a), 32'd6);
      tick();
      m_read = 1'b0;
      @(negedge clock);
      check("lit t6 rdv", 32'(avm_a.m_readdatavalid), 32'd1);
      check("lit t6 data", avm_a.m_readdata, TS);
      tick();
      @(negedge clock);
      check("lit t6 no second check", 32'(avm_a.m_waitrequest), 32'd0);
      check("lit t6 count final", 32'(cnt_a), 32'd6);

      // Test 5b: reset during CHK_TS abandons the check, then a fresh one completes.
      recheck = 1'b1;
      tick();
      recheck = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("lit t5 rst done", 32'(done_a), 32'd0);
      check("lit t5 rst count8", 32'(cnt_a), 32'd0);
      check("lit t5 rst count2", 32'(cnt_b), 32'd0);
      check("lit t5 rst mismatch", 32'(mis_a), 32'd0);
      check("lit t5 rst rdv", 32'(avm_a.m_readdatavalid), 32'd0);
      tick();
      reset = 1'b0;
      bad_id = 1'b0;
      tick();
      tick();
      @(negedge clock);
      check("lit t5 recheck done", 32'(done_a), 32'd1);
      check("lit t5 recheck ok", 32'(ok_a), 32'd1);
      check("lit t5 recheck count", 32'(cnt_a), 32'd0);

      tick();
      tick();
      @(negedge clock);
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
